set_ro_param: RTL
=================

Name: set_ro_param

Overview:
- Parametrised successor to the fixed 128x256 read-only cache set.
- Line count, words per line and physical address width are configurable.
- Adds an integrated line-fill sequencer: critical-word-first ordering, a handshake, an automatic tag write with validation, and abort.
- Sits in the instruction-cache datapath as one way. A cache controller drives the fill port from the memory interface.

Parameters:
PABITS, 36, physical address width; tag width TW = PABITS-INDEX_BITS-OFFSET_BITS-2
INDEX_BITS, 8, log2(line count)
OFFSET_BITS, 2, log2(32-bit words per line)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
Tag  in  TW  lookup tag
Index  in  INDEX_BITS  lookup/tag-op line index
Offset  in  OFFSET_BITS  lookup word offset
WordOut  out  32  registered read word
Hit  out  1  registered: line valid and stored tag == Tag
Valid  out  1  registered line-valid
ValidateLine  in  1  write Tag at Index, valid=2'b11
InvalidateLine  in  1  clear valid at Index
StoreTag  in  1  write StoreTagData at Index
StoreTagData  in  TW+2  {tag, valid[1:0]}; line valid = |valid
FillStart  in  1  begin fill (accepted only when FillBusy=0)
FillTag  in  TW  tag for the filled line
FillIndex  in  INDEX_BITS  line being filled
FillCritOffset  in  OFFSET_BITS  first word offset delivered
FillWordIn  in  32  fill data
FillWordValid  in  1  FillWordIn valid this cycle
FillAbort  in  1  abandon fill
FillBusy  out  1  sequencer in FILL
FillDone  out  1  one-cycle pulse: line completed and validated

Behaviour:
- Reset: all valid bits cleared (flop array). WordOut=0, Hit=0, Valid=0, FillBusy=0, FillDone=0. Data array is not cleared. A reset during a fill returns the sequencer to IDLE.
- Lookup latency is 1 cycle. Outputs after edge N reflect Tag/Index/Offset sampled at edge N.
- Lookups are write-first. A tag op or fill word written at edge N to the looked-up line/word appears in the outputs after edge N.
- Tag-op priority: InvalidateLine > StoreTag > ValidateLine. Only one is applied per cycle.
- FSM IDLE:
  - FillStart latches FillTag, FillIndex and FillCritOffset.
  - It clears the valid bit at FillIndex in the same edge.
  - Word count is set to 0 and the FSM goes to FILL, with FillBusy=1 from the next cycle.
- FSM FILL:
  - Each FillWordValid writes FillWordIn at offset (FillCritOffset+count) mod 2^OFFSET_BITS, then count++.
  - Gaps with FillWordValid=0 are allowed and hold state.
  - On the final word (count == 2^OFFSET_BITS-1), the same edge writes tag=FillTag with valid=2'b11 and the FSM returns to IDLE.
  - FillDone=1 for exactly the cycle after that edge.
- FillAbort in FILL returns to IDLE. The line stays invalid and FillDone is not pulsed. FillAbort has priority over a simultaneous FillWordValid.
- FillStart while FillBusy=1 is ignored. FillAbort in IDLE is ignored.
- During FILL:
  - InvalidateLine at FillIndex aborts the fill.
  - StoreTag/ValidateLine at FillIndex are ignored.
  - Tag ops at other indices proceed normally.
- A lookup of the line being filled returns Valid=0, Hit=0 (unless the optional feature is enabled). WordOut still returns the array contents.
- Offset arithmetic wraps modulo 2^OFFSET_BITS. No other width growth.

Optional Feature:
SET_RO_EARLY_RESTART_EN
- Defined: the sequencer keeps a per-word written mask. A lookup with Index==FillIndex, Tag==FillTag and a mask bit set for Offset returns Hit=1, Valid=1 with the written word, before the fill completes.
- Undefined: no mask; the filling line reports Hit=0/Valid=0 until completion.

Test Plan:
1. Reset, then lookup Tag=24'h654321, Index=8'h76 -> Hit=0, Valid=0.
2. ValidateLine tag 24'h654321 at 8'h76 -> Hit=1, Valid=1 next cycle. InvalidateLine the same -> Hit=0, Valid=0. StoreTag {24'hcccccc,2'b00} at 8'hff -> Valid=0.
3. FillStart tag 24'h654321, idx 8'h76, crit 2'b10; words 33333333, 44444444, (gap cycle), 11111111, 22222222 -> FillDone pulses once after the 4th word. Lookups at offsets 0..3 -> Hit=1, words 11111111/22222222/33333333/44444444.
4. Fill idx 8'h77, abort after 2 words -> FillBusy=0, no FillDone, lookup at 8'h77 gives Valid=0. FillStart during a busy fill is ignored (FillTag unchanged).
5. Reset asserted mid-fill -> FillBusy=0, all lookups Valid=0. A new FillStart is accepted next cycle.
6. With SET_RO_EARLY_RESTART_EN, fill crit 2'b01 and write the first word 22222222 -> lookup offset 1 gives Hit=1, 22222222, and offset 0 gives Hit=0. Without the macro, both give Hit=0.

Source files
------------

// File: rtl/set_ro_param_if.sv
// set_ro_param_if: lookup, tag-op and line-fill signals of one read-only cache way
interface set_ro_param_if #(
    parameter int PABITS      = 36,
    parameter int INDEX_BITS  = 8,
    parameter int OFFSET_BITS = 2
);
    localparam int TW = PABITS - INDEX_BITS - OFFSET_BITS - 2;
    logic [TW-1:0]          Tag;
    logic [INDEX_BITS-1:0]  Index;
    logic [OFFSET_BITS-1:0] Offset;
    logic [31:0]            WordOut;
    logic                   Hit;
    logic                   Valid;
    logic                   ValidateLine;
    logic                   InvalidateLine;
    logic                   StoreTag;
    logic [TW+1:0]          StoreTagData;
    logic                   FillStart;
    logic [TW-1:0]          FillTag;
    logic [INDEX_BITS-1:0]  FillIndex;
    logic [OFFSET_BITS-1:0] FillCritOffset;
    logic [31:0]            FillWordIn;
    logic                   FillWordValid;
    logic                   FillAbort;
    logic                   FillBusy;
    logic                   FillDone;
    modport master (
        output Tag, Index, Offset, ValidateLine, InvalidateLine, StoreTag, StoreTagData,
               FillStart, FillTag, FillIndex, FillCritOffset, FillWordIn, FillWordValid, FillAbort,
        input  WordOut, Hit, Valid, FillBusy, FillDone
    );
    modport slave (
        input  Tag, Index, Offset, ValidateLine, InvalidateLine, StoreTag, StoreTagData,
               FillStart, FillTag, FillIndex, FillCritOffset, FillWordIn, FillWordValid, FillAbort,
        output WordOut, Hit, Valid, FillBusy, FillDone
    );
endinterface

// File: rtl/set_ro_param.sv
// set_ro_param: parametrised read-only cache way with critical-word-first line-fill sequencer.
// Optional SET_RO_EARLY_RESTART_EN lets already-filled words of the filling line hit early.
module set_ro_param #(
    parameter int PABITS      = 36,
    parameter int INDEX_BITS  = 8,
    parameter int OFFSET_BITS = 2
) (
    input logic           clock,
    input logic           reset,
    set_ro_param_if.slave bus
);
    localparam int TW    = PABITS - INDEX_BITS - OFFSET_BITS - 2;
    localparam int LINES = 2 ** INDEX_BITS;
    localparam int WORDS = 2 ** OFFSET_BITS;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [TW-1:0]          tag_mem   [LINES];
    logic [1:0]             valid_mem [LINES];
    logic [31:0]            data_mem  [LINES*WORDS];
    logic [0:0]             state;
    logic [TW-1:0]          f_tag;
    logic [INDEX_BITS-1:0]  f_idx;
    logic [OFFSET_BITS-1:0] f_crit, count, wr_off;
    logic                   done;
    logic                   filling, at_fill, abort, word_wr, last, start, er_hit;
    logic                   op_v_en, op_t_en, fsm_v_en, fsm_t_en;
    logic [1:0]             op_v, fsm_v, look_v;
    logic [TW-1:0]          op_t, look_t;
    logic [INDEX_BITS-1:0]  fsm_idx;
    logic [31:0]            look_w;

    // Two write ports per edge: the tag-op port at Index and the sequencer port at fsm_idx
    always_comb begin
        filling  = state == FILL;
        at_fill  = filling && bus.Index == f_idx;
        abort    = filling && (bus.FillAbort || (bus.InvalidateLine && at_fill));
        word_wr  = filling && !abort && bus.FillWordValid;
        wr_off   = f_crit + count;
        last     = word_wr && count == '1;
        start    = !filling && bus.FillStart;
        op_v_en  = bus.InvalidateLine || ((bus.StoreTag || bus.ValidateLine) && !at_fill);
        op_t_en  = !bus.InvalidateLine && (bus.StoreTag || bus.ValidateLine) && !at_fill;
        op_v     = bus.InvalidateLine ? 2'b00 : bus.StoreTag ? bus.StoreTagData[1:0] : 2'b11;
        op_t     = bus.StoreTag ? bus.StoreTagData[TW+1:2] : bus.Tag;
        fsm_v_en = start || last;
        fsm_t_en = last;
        fsm_idx  = start ? bus.FillIndex : f_idx;
        fsm_v    = last ? 2'b11 : 2'b00;
        look_v   = fsm_v_en && fsm_idx == bus.Index ? fsm_v : op_v_en ? op_v : valid_mem[bus.Index];
        look_t   = fsm_t_en && fsm_idx == bus.Index ? f_tag : op_t_en ? op_t : tag_mem[bus.Index];
        look_w   = word_wr && at_fill && bus.Offset == wr_off ? bus.FillWordIn
                                                              : data_mem[{bus.Index, bus.Offset}];
    end

`ifdef SET_RO_EARLY_RESTART_EN
    logic [WORDS-1:0] mask, mask_nx;
    always_comb begin
        mask_nx = start ? '0 : word_wr ? mask | (WORDS'(1) << wr_off) : mask;
        er_hit  = at_fill && !abort && bus.Tag == f_tag && mask_nx[bus.Offset];
    end
    always_ff @(posedge clock) mask <= reset ? '0 : mask_nx;
`else
    assign er_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) valid_mem[i] <= 2'b00;
            state       <= IDLE;
            done        <= 1'b0;
            bus.WordOut <= '0;
            bus.Hit     <= 1'b0;
            bus.Valid   <= 1'b0;
        end else begin
            if (op_v_en) valid_mem[bus.Index] <= op_v;
            if (op_t_en) tag_mem[bus.Index] <= op_t;
            if (fsm_v_en) valid_mem[fsm_idx] <= fsm_v;
            if (fsm_t_en) tag_mem[fsm_idx] <= f_tag;
            done  <= last;
            state <= start ? FILL : (abort || last) ? IDLE : state;
            if (start) begin
                f_tag  <= bus.FillTag;
                f_idx  <= bus.FillIndex;
                f_crit <= bus.FillCritOffset;
                count  <= '0;
            end else if (word_wr) begin
                count <= count + 1'b1;
            end
            bus.WordOut <= look_w;
            bus.Hit     <= (|look_v && look_t == bus.Tag) || er_hit;
            bus.Valid   <= |look_v || er_hit;
        end
    end

    always_ff @(posedge clock)
        if (word_wr && !reset) data_mem[{f_idx, wr_off}] <= bus.FillWordIn;

    assign bus.FillBusy = state == FILL;
    assign bus.FillDone = done;
endmodule
